// File: rtl/frontend_sw_ctrl.sv
// ============================================================================
// Module   : frontend_sw_ctrl
// Purpose  : Sequences the front-end channel-swap mux select so that a swap
//            is always bracketed by a downstream blanking window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frontend_sw_ctrl #(
    parameter int BASE          = 0,
    parameter int TIMEOUT       = 65535,
    parameter int DEFAULT_BLANK = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic        run_0,
    input  logic        run_1,
    output logic        front_sw,
    output logic        blank,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  swap_count
);

    localparam int              CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   WAIT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [7:0]      ADDR_CTRL  = 8'(BASE);
    localparam logic [7:0]      ADDR_BLANK = 8'(BASE + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_BLANK  = 3'd2,
        S_APPLY  = 3'd3,
        S_SETTLE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          target_q, force_q;
    logic [15:0]   blank_len_q, len_q, blk_cnt_q;
    logic [CW-1:0] wait_cnt_q;
    logic          front_sw_q, blank_q, busy_q, timeout_err_q;
    logic [7:0]    swap_count_q;
    logic          timeout_hit_d;
    logic          w_wr_ctrl, w_wr_blank, w_unused;

    assign w_wr_ctrl  = set_stb && (set_addr == ADDR_CTRL);
    assign w_wr_blank = set_stb && (set_addr == ADDR_BLANK);
    assign w_unused   = ^set_data[31:16];

    always_comb begin
        state_d       = state_q;
        timeout_hit_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (target_q != front_sw_q)
                    state_d = force_q ? S_BLANK : S_WAIT;
            end
            S_WAIT: begin
                if (target_q == front_sw_q) begin
                    state_d = S_IDLE;
                end else if (force_q || (!run_0 && !run_1)) begin
                    state_d = S_BLANK;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d       = S_BLANK;
                    timeout_hit_d = 1'b1;
                end
            end
            S_BLANK:  if (blk_cnt_q == len_q - 16'd1) state_d = S_APPLY;
            S_APPLY:  state_d = S_SETTLE;
            S_SETTLE: if (blk_cnt_q == len_q - 16'd1) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            target_q      <= 1'b0;
            force_q       <= 1'b0;
            blank_len_q   <= 16'(DEFAULT_BLANK);
            len_q         <= 16'd1;
            blk_cnt_q     <= 16'd0;
            wait_cnt_q    <= '0;
            front_sw_q    <= 1'b0;
            blank_q       <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            swap_count_q  <= 8'd0;
        end else begin
            state_q <= state_d;

            if (w_wr_ctrl) begin
                target_q <= set_data[0];
                force_q  <= set_data[1];
            end
            if (w_wr_blank)
                blank_len_q <= set_data[15:0];

            // A clear request wins over a timeout landing on the same edge.
            if (w_wr_ctrl && set_data[2])
                timeout_err_q <= 1'b0;
            else if (timeout_hit_d)
                timeout_err_q <= 1'b1;

            // Blank length is frozen for the whole swap on entry to BLANK.
            if (state_d == S_BLANK && state_q != S_BLANK)
                len_q <= (blank_len_q == 16'd0) ? 16'd1 : blank_len_q;

            if ((state_q == S_BLANK || state_q == S_SETTLE) && state_d == state_q)
                blk_cnt_q <= blk_cnt_q + 16'd1;
            else
                blk_cnt_q <= 16'd0;

            wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + 1'b1 : '0;

            if (state_q == S_APPLY) begin
                front_sw_q   <= ~front_sw_q;
                swap_count_q <= swap_count_q + 8'd1;
            end

            blank_q <= (state_d == S_BLANK) || (state_d == S_APPLY) || (state_d == S_SETTLE);
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign front_sw    = front_sw_q;
    assign blank       = blank_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign swap_count  = swap_count_q;

endmodule

`default_nettype wire

// File: tb/tb_frontend_sw_ctrl.sv
// ============================================================================
// Module   : tb_frontend_sw_ctrl
// Purpose  : Directed self-checking bench for frontend_sw_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frontend_sw_ctrl;

    localparam int BASE = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'd0;
    logic [31:0] set_data = 32'd0;
    logic        run_0 = 1'b0;
    logic        run_1 = 1'b0;
    logic        front_sw, blank, busy, timeout_err;
    logic [7:0]  swap_count;

    int checks = 0;
    int errors = 0;

    frontend_sw_ctrl #(
        .BASE(BASE), .TIMEOUT(100), .DEFAULT_BLANK(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .run_0(run_0), .run_1(run_1),
        .front_sw(front_sw), .blank(blank), .busy(busy),
        .timeout_err(timeout_err), .swap_count(swap_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        tick();
        set_stb  = 1'b0;
        set_data = 32'd0;
    endtask

    logic bad;

    initial begin
        #12;
        chk("rst_front_sw", front_sw, 0);
        chk("rst_blank", blank, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_count", swap_count, 0);
        rst_n = 1'b1;
        tick(2);

        // Idle swap, L=4: 9-cycle blank window, select flips on 5th boundary
        wr(8'(BASE + 1), 32'd4);
        wr(8'(BASE), 32'h1);
        chk("idle_busy0", busy, 0);
        tick();
        chk("idle_wait_busy", busy, 1);
        chk("idle_wait_blank", blank, 0);
        tick();
        bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (blank !== 1'b1 || busy !== 1'b1) bad = 1'b1;
            if (front_sw !== ((i >= 5) ? 1'b1 : 1'b0)) bad = 1'b1;
            tick();
        end
        chk("idle_window", bad, 0);
        chk("idle_blank_end", blank, 0);
        chk("idle_busy_end", busy, 0);
        chk("idle_front_sw", front_sw, 1);
        chk("idle_count", swap_count, 1);

        // Wait for idle: held off while run_0 busy
        run_0 = 1'b1;
        wr(8'(BASE), 32'h0);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (blank !== 1'b0) bad = 1'b1;
            tick();
        end
        chk("hold_blank", bad, 0);
        chk("hold_busy", busy, 1);
        run_0 = 1'b0;
        tick();
        chk("hold_release_blank", blank, 1);
        chk("hold_terr", timeout_err, 0);
        tick(9);
        chk("hold_front_sw", front_sw, 0);
        chk("hold_count", swap_count, 2);
        chk("hold_busy_end", busy, 0);

        // Timeout after 100 wait cycles
        run_1 = 1'b1;
        wr(8'(BASE), 32'h1);
        tick();
        bad = 1'b0;
        for (int i = 0; i < 99; i++) begin
            if (blank !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            tick();
        end
        chk("to_hold", bad, 0);
        chk("to_terr_pre", timeout_err, 0);
        tick();
        chk("to_blank", blank, 1);
        chk("to_terr", timeout_err, 1);
        tick(9);
        chk("to_front_sw", front_sw, 1);
        chk("to_count", swap_count, 3);
        wr(8'(BASE), 32'h5);
        chk("to_clear", timeout_err, 0);
        tick(3);
        chk("to_no_swap_busy", busy, 0);
        chk("to_no_swap_cnt", swap_count, 3);
        run_1 = 1'b0;

        // Force: no wait even with run_0 active
        run_0 = 1'b1;
        wr(8'(BASE), 32'h2);
        tick();
        chk("force_blank", blank, 1);
        tick(9);
        chk("force_front_sw", front_sw, 0);
        chk("force_count", swap_count, 4);

        // Withdraw while waiting
        wr(8'(BASE), 32'h0);
        wr(8'(BASE), 32'h1);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (blank !== 1'b0) bad = 1'b1;
            tick();
        end
        wr(8'(BASE), 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (blank !== 1'b0) bad = 1'b1;
            tick();
        end
        chk("wd_blank", bad, 0);
        chk("wd_busy", busy, 0);
        chk("wd_count", swap_count, 4);
        run_0 = 1'b0;

        // Retarget during BLANK with blank_len=0 (3-cycle windows)
        wr(8'(BASE + 1), 32'd0);
        wr(8'(BASE), 32'h1);
        tick(2);
        chk("rt_blank1", blank, 1);
        wr(8'(BASE), 32'h0);
        chk("rt_apply_sw", front_sw, 0);
        chk("rt_apply_blank", blank, 1);
        tick();
        chk("rt_settle_sw", front_sw, 1);
        tick();
        chk("rt_gap_blank", blank, 0);
        chk("rt_count1", swap_count, 5);
        tick(2);
        chk("rt_blank2", blank, 1);
        tick(2);
        chk("rt_settle2_sw", front_sw, 0);
        tick();
        chk("rt_end_blank", blank, 0);
        chk("rt_count2", swap_count, 6);
        tick();
        chk("rt_end_busy", busy, 0);

        // Asynchronous reset during BLANK
        wr(8'(BASE + 1), 32'd4);
        wr(8'(BASE), 32'h1);
        tick(3);
        chk("ar_pre_blank", blank, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_blank", blank, 0);
        chk("ar_busy", busy, 0);
        chk("ar_count", swap_count, 0);
        chk("ar_front_sw", front_sw, 0);
        #3 rst_n = 1'b1;
        tick(12);
        chk("ar_after_busy", busy, 0);
        chk("ar_after_sw", front_sw, 0);
        chk("ar_after_cnt", swap_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
